// File: rtl/uart_ram_loader_pkg.sv
// Shared definitions for the UART boot loader: bus widths, loader state
// encoding and default sizing constants.
package uart_ram_loader_pkg;

   localparam int INST_ADDR_BUS      = 32;
   localparam int INST_DATA_BUS      = 32;
   localparam int BYTE_WIDTH         = 8;
   localparam int DEF_RAM_DEPTH      = 4096;
   localparam int DEF_TIMEOUT_CYCLES = 1_000_000;

   typedef enum logic [1:0] {
      S_LEN  = 2'd0,
      S_DATA = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } loader_state_e;

endpackage

// File: rtl/uart_ram_loader_byte_word_packer.sv
// Packs a byte stream into little-endian 32-bit words; word_valid_o fires
// combinationally with the 4th byte so the caller can register the write.
module byte_word_packer
   import uart_ram_loader_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     clr_i,
   input  logic                     byte_valid_i,
   input  logic [BYTE_WIDTH-1:0]    byte_i,
   output logic [INST_DATA_BUS-1:0] word_o,
   output logic                     word_valid_o,
   output logic [1:0]               byte_cnt_o
);

   localparam int PART_W = INST_DATA_BUS - BYTE_WIDTH;

   logic [PART_W-1:0] partial_q;
   logic [1:0]        cnt_q;

   // New bytes enter at the top and shift down, so after three bytes the
   // oldest one sits in [7:0].
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         partial_q <= '0;
         cnt_q     <= 2'd0;
      end else if (clr_i) begin
         partial_q <= '0;
         cnt_q     <= 2'd0;
      end else if (byte_valid_i) begin
         partial_q <= {byte_i, partial_q[PART_W-1:BYTE_WIDTH]};
         cnt_q     <= cnt_q + 2'd1;
      end
   end

   assign word_o       = {byte_i, partial_q};
   assign word_valid_o = byte_valid_i && !clr_i && (cnt_q == 2'd3);
   assign byte_cnt_o   = cnt_q;

endmodule

// File: rtl/uart_ram_loader.sv
// Boot loader: reads a 32-bit word count then that many words from the UART,
// writes them to instruction RAM and releases the core once the image is in.
module uart_ram_loader
   import uart_ram_loader_pkg::*;
#(
   parameter logic [INST_ADDR_BUS-1:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned              RAM_DEPTH      = DEF_RAM_DEPTH,
   parameter int unsigned              TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)(
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     rx_valid_i,
   input  logic [BYTE_WIDTH-1:0]    rx_data_i,
   output logic                     wen_o,
   output logic [INST_ADDR_BUS-1:0] waddr_o,
   output logic [INST_DATA_BUS-1:0] wdata_o,
   output logic                     core_rst_n_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o
);

   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] DEPTH_W  = 32'(RAM_DEPTH);

   loader_state_e            state;
   logic [31:0]              n_words;
   logic [31:0]              idx;
   logic [31:0]              tmo_cnt;
   logic [INST_DATA_BUS-1:0] pk_word;
   logic                     pk_valid;
   logic [1:0]               pk_cnt;
   logic                     in_frame;
   logic                     timing;
   logic                     tmo_hit;

   assign in_frame = (state == S_LEN) || (state == S_DATA);
   // The idle length phase (no byte yet) may wait forever for a host.
   assign timing   = (state == S_DATA) || ((state == S_LEN) && (pk_cnt != 2'd0));
   assign tmo_hit  = timing && !rx_valid_i && (tmo_cnt == TMO_LAST);

   byte_word_packer u_packer (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .clr_i        (tmo_hit),
      .byte_valid_i (rx_valid_i && in_frame),
      .byte_i       (rx_data_i),
      .word_o       (pk_word),
      .word_valid_o (pk_valid),
      .byte_cnt_o   (pk_cnt)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)                   tmo_cnt <= '0;
      else if (rx_valid_i || !timing) tmo_cnt <= '0;
      else                            tmo_cnt <= tmo_cnt + 32'd1;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state        <= S_LEN;
         n_words      <= '0;
         idx          <= '0;
         wen_o        <= 1'b0;
         waddr_o      <= BASE_ADDR;
         wdata_o      <= '0;
         core_rst_n_o <= 1'b0;
      end else begin
         wen_o <= 1'b0;
         case (state)
            S_LEN: begin
               if (tmo_hit) begin
                  state <= S_ERR;
               end else if (pk_valid) begin
                  n_words <= pk_word;
                  idx     <= '0;
                  if (pk_word == 32'd0) begin
                     state        <= S_DONE;
                     core_rst_n_o <= 1'b1;
                  end else if (pk_word > DEPTH_W) begin
                     state <= S_ERR;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (tmo_hit) begin
                  state <= S_ERR;
               end else if (pk_valid) begin
                  wen_o   <= 1'b1;
                  wdata_o <= pk_word;
                  waddr_o <= BASE_ADDR + {idx[29:0], 2'b00};
                  idx     <= idx + 32'd1;
                  if (idx == n_words - 32'd1) begin
                     state        <= S_DONE;
                     core_rst_n_o <= 1'b1;
                  end
               end
            end
            S_DONE:  core_rst_n_o <= 1'b1;
            S_ERR:   core_rst_n_o <= 1'b0;
            default: state <= S_ERR;
         endcase
      end
   end

   assign busy_o = timing;
   assign done_o = (state == S_DONE);
   assign err_o  = (state == S_ERR);

endmodule

// File: tb/tb_uart_ram_loader.sv
// Randomized bench for uart_ram_loader: frames are built from an image list,
// and expected RAM writes are derived from the image and byte timestamps.
module tb_uart_ram_loader;

   localparam int          TMO   = 40;
   localparam int          DEPTH = 4096;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        wen;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic        core_rst_n;
   logic        busy;
   logic        done;
   logic        err;

   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned cyc     = 0;

   logic [63:0] exp_q[$];
   int unsigned exp_cyc_q[$];
   logic [63:0] obs_q[$];
   int unsigned obs_cyc_q[$];
   int unsigned byte_cyc_q[$];
   logic [31:0] img_q[$];

   uart_ram_loader #(
      .BASE_ADDR      (BASE),
      .RAM_DEPTH      (DEPTH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .rx_valid_i   (rx_valid),
      .rx_data_i    (rx_data),
      .wen_o        (wen),
      .waddr_o      (waddr),
      .wdata_o      (wdata),
      .core_rst_n_o (core_rst_n),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wen) begin
         obs_q.push_back({waddr, wdata});
         obs_cyc_q.push_back(cyc);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic clear_sb();
      exp_q.delete();
      exp_cyc_q.delete();
      obs_q.delete();
      obs_cyc_q.delete();
      byte_cyc_q.delete();
   endtask

   // driver: one byte strobe, then 'gap' idle cycles
   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      byte_cyc_q.push_back(cyc);
      rx_valid = 1'b0;
      if (gap > 0) tick(gap);
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, " wen"},        64'(wen),        64'(0));
      check_eq({tag, " waddr"},      64'(waddr),      64'(BASE));
      check_eq({tag, " wdata"},      64'(wdata),      64'(0));
      check_eq({tag, " core_rst_n"}, 64'(core_rst_n), 64'(0));
      check_eq({tag, " busy"},       64'(busy),       64'(0));
      check_eq({tag, " done"},       64'(done),       64'(0));
      check_eq({tag, " err"},        64'(err),        64'(0));
   endtask

   task automatic compare_writes(input string tag);
      check_eq({tag, " nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         check_eq($sformatf("%s write%0d", tag, i), obs_q[i], exp_q[i]);
         check_eq($sformatf("%s latency%0d", tag, i), 64'(obs_cyc_q[i]), 64'(exp_cyc_q[i]));
      end
   endtask

   // Full frame: length n, then img_q (must hold n words when n is legal).
   // Byte number long_idx is followed by TMO-1 idle cycles, the longest legal gap.
   task automatic run_frame(input logic [31:0] n, input int max_gap, input int long_idx,
                            input string tag);
      int  b;
      int  gap;
      logic [31:0] w;
      bit  legal;
      clear_sb();
      legal = (n != 0) && (n <= DEPTH);
      b = 0;
      for (int k = 0; k < 4; k++) begin
         gap = (b == long_idx) ? TMO - 1 : int'($urandom_range(0, max_gap));
         send_byte(n[8*k +: 8], gap);
         b++;
      end
      if (legal) begin
         for (int i = 0; i < img_q.size(); i++) begin
            w = img_q[i];
            for (int k = 0; k < 4; k++) begin
               gap = (b == long_idx) ? TMO - 1 : int'($urandom_range(0, max_gap));
               send_byte(w[8*k +: 8], gap);
               b++;
            end
         end
         for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back({BASE + 32'(4 * i), img_q[i]});
            exp_cyc_q.push_back(byte_cyc_q[4 + 4*i + 3]);
         end
      end
      tick(2);
      compare_writes(tag);
      check_eq({tag, " done"},       64'(done),       64'(n <= DEPTH));
      check_eq({tag, " core_rst_n"}, 64'(core_rst_n), 64'(n <= DEPTH));
      check_eq({tag, " err"},        64'(err),        64'(n > DEPTH));
      check_eq({tag, " busy"},       64'(busy),       64'(0));
   endtask

   task automatic random_image(input int n);
      img_q.delete();
      for (int i = 0; i < n; i++) img_q.push_back($urandom);
   endtask

   initial begin
      int n;
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tick(3);
      check_reset_vals("reset");
      rst_n = 1'b1;

      // idle length phase never times out
      tick(3 * TMO);
      check_eq("idle err",  64'(err),  64'(0));
      check_eq("idle busy", 64'(busy), 64'(0));

      // empty image, then bytes ignored once done
      img_q.delete();
      run_frame(32'd0, 1, -1, "n0");
      clear_sb();
      for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
      tick(2);
      check_eq("done ignore nwrites", 64'(obs_q.size()), 64'(0));
      check_eq("done ignore done",    64'(done),         64'(1));

      // fixed two-word image
      do_reset();
      img_q.delete();
      img_q.push_back(32'h0000_0013);
      img_q.push_back(32'h0001_05B7);
      run_frame(32'd2, 1, -1, "fixed");
      if (obs_q.size() == 2) begin
         check_eq("fixed w0 abs", obs_q[0], {32'h0000_0000, 32'h0000_0013});
         check_eq("fixed w1 abs", obs_q[1], {32'h0000_0004, 32'h0001_05B7});
      end else begin
         check_eq("fixed count abs", 64'(obs_q.size()), 64'(2));
      end

      // back-to-back bytes, rx_valid held high
      do_reset();
      random_image(2);
      run_frame(32'd2, 0, -1, "b2b");

      // random loads, some with the longest legal inter-byte gap
      for (int t = 0; t < 6; t++) begin
         do_reset();
         n = int'($urandom_range(1, 8));
         random_image(n);
         run_frame(32'(n), 3, (t % 2 == 0) ? int'($urandom_range(1, 4 + 4*n - 2)) : -1,
                   $sformatf("rnd%0d", t));
      end

      // oversize image rejected, bytes ignored afterwards
      do_reset();
      img_q.delete();
      run_frame(32'h0000_1001, 1, -1, "oversize");
      clear_sb();
      for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
      tick(2);
      check_eq("err ignore nwrites",   64'(obs_q.size()), 64'(0));
      check_eq("err ignore err",       64'(err),          64'(1));
      check_eq("err ignore core_rst_n", 64'(core_rst_n),  64'(0));

      // exactly RAM_DEPTH words is accepted
      do_reset();
      clear_sb();
      send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      tick(2);
      check_eq("depth busy", 64'(busy), 64'(1));
      check_eq("depth err",  64'(err),  64'(0));

      // timeout in payload with a partial word
      do_reset();
      clear_sb();
      send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
      tick(TMO - 1);
      check_eq("tmo early err",  64'(err),  64'(0));
      check_eq("tmo early busy", 64'(busy), 64'(1));
      tick(1);
      check_eq("tmo err",        64'(err),          64'(1));
      check_eq("tmo busy",       64'(busy),         64'(0));
      check_eq("tmo core_rst_n", 64'(core_rst_n),   64'(0));
      tick(4);
      check_eq("tmo nwrites",    64'(obs_q.size()), 64'(0));
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(1);
      check_reset_vals("tmo reset");

      // timeout inside the length field
      clear_sb();
      send_byte(8'h02, 0); send_byte(8'h00, 0);
      tick(TMO);
      check_eq("len tmo err", 64'(err), 64'(1));

      // asynchronous reset while a write is on the port, then reload
      do_reset();
      clear_sb();
      random_image(2);
      send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      for (int k = 0; k < 4; k++) send_byte(img_q[0][8*k +: 8], 0);
      check_eq("mid wen before", 64'(wen), 64'(1));
      #1 rst_n = 1'b0;
      #1;
      check_eq("mid wen async",        64'(wen),        64'(0));
      check_eq("mid core_rst_n async", 64'(core_rst_n), 64'(0));
      tick(1);
      rst_n = 1'b1;
      tick(1);
      check_eq("mid nwrites", 64'(obs_q.size()), 64'(0));
      random_image(2);
      run_frame(32'd2, 2, -1, "reload");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_ram_loader.md
Name: uart_ram_loader

Overview:
- Boot-time program loader that sits directly upstream of the instruction RAM and drives its write port (write enable, write address, write data).
- Consumes a byte stream from the UART receiver and packs it into little-endian 32-bit words.
- Issues one RAM write per word.
- Holds the RISC-V core in reset until the image is fully written, then releases it.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be 4-byte aligned.
- RAM_DEPTH, 4096, RAM capacity in 32-bit words; images longer than this are rejected.
- TIMEOUT_CYCLES, 1_000_000, maximum clk_i cycles allowed between bytes once a frame has started.

Ports:
- clk_i  input  1  system clock
- rst_n_i  input  1  reset, asynchronous, active-low
- rx_valid_i  input  1  one-cycle strobe: rx_data_i holds a received byte
- rx_data_i  input  8  received byte
- wen_o  output  1  RAM write enable, one-cycle pulse per word
- waddr_o  output  32  RAM byte write address, bits [1:0] always 00
- wdata_o  output  32  RAM write data
- core_rst_n_o  output  1  active-low reset to the core; 0 while loading
- busy_o  output  1  frame in progress (LEN with bytes received, or DATA)
- done_o  output  1  image loaded, sticky
- err_o  output  1  load failed, sticky

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_n_i is asynchronous and active-low. All flops clear on reset.
- Reset values:
  - wen_o=0, waddr_o=BASE_ADDR, wdata_o=0
  - core_rst_n_o=0, busy_o=0, done_o=0, err_o=0
  - state=S_LEN, byte counter=0, word index=0, timeout counter=0
- No backpressure: every rx_valid_i pulse is consumed in the cycle it is sampled. Bytes are never dropped in S_LEN or S_DATA.
- Byte packing: bytes fill the word LSB first (byte0 -> [7:0], byte3 -> [31:24]). A 2-bit byte counter wraps 3->0.
- State S_LEN:
  - Collect 4 bytes into a 32-bit word count N.
  - On the 4th byte: N==0 -> S_DONE; N>RAM_DEPTH -> S_ERR; otherwise -> S_DATA.
- State S_DATA:
  - On the 4th byte of a word, the next cycle has wen_o=1 for exactly one cycle, with wdata_o=packed word and waddr_o=BASE_ADDR+4*idx.
  - idx then increments.
  - When the write for idx==N-1 is issued, the next state is S_DONE.
  - Write latency is 1 cycle from the 4th byte's rx_valid_i.
- Simultaneous events: rx_valid_i in the same cycle as wen_o is accepted normally. The write-output register is independent of the packing register, so back-to-back bytes at one per cycle sustain one write per 4 cycles.
- Timeout:
  - The counter clears on every rx_valid_i.
  - It counts only in S_DATA, or in S_LEN with byte counter != 0.
  - On reaching TIMEOUT_CYCLES-1 with no byte, go to S_ERR; a partial word is discarded and never written.
  - S_LEN with byte counter==0 waits indefinitely.
- State S_DONE: core_rst_n_o=1, done_o=1, busy_o=0, wen_o=0. rx bytes are ignored (the UART is then owned by the core). Only rst_n_i exits this state.
- State S_ERR: err_o=1, core_rst_n_o=0, wen_o=0, busy_o=0. rx bytes are ignored. Only rst_n_i exits this state.
- Reset mid-load: asserting rst_n_i immediately clears wen_o and core_rst_n_o. The partially written RAM content is left as is. The next load starts from S_LEN.
- Widths: idx is 32 bits. Address arithmetic is modulo 2^32. Because N<=RAM_DEPTH, the address cannot wrap for sane BASE_ADDR.
- Outputs are registered except busy_o, done_o and err_o, which are decoded from state.

Decomposition:
- Shared define package (alongside the existing INST_ADDR_BUS / INST_DATA_BUS / RAM_DEPTH macros) holds:
  - loader state encoding: S_LEN, S_DATA, S_DONE, S_ERR
  - BYTE_WIDTH=8
  - default TIMEOUT_CYCLES constant
- Natural sub-module byte_word_packer: rx byte strobe in; 32-bit word plus word_valid pulse out; sync clear input (used on timeout and state change).
- The FSM, address generation and timeout counter stay in uart_ram_loader.

Test Plan:
- Send 00 00 00 00 -> done_o=1 and core_rst_n_o=1 within 2 cycles of the 4th byte; wen_o never asserted.
- Send length 02 00 00 00, then 13 00 00 00 B7 05 01 00 -> wen_o pulses twice: addr 0x0 data 0x00000013, then addr 0x4 data 0x000105B7; then done_o=1.
- Bytes on consecutive cycles (rx_valid_i held 1 for 12 cycles, N=2) -> each wen_o occurs 1 cycle after its 4th byte and no byte is lost.
- Length 0x00001001 with RAM_DEPTH=4096 -> err_o=1, core_rst_n_o stays 0, no writes.
- N=1, send 3 payload bytes, then idle TIMEOUT_CYCLES -> err_o=1, no wen_o; then pulse rst_n_i low -> all outputs return to reset values.
- Assert rst_n_i mid-payload (after 5 of 8 bytes) -> wen_o and core_rst_n_o drop asynchronously; a full reload then completes with correct data.
